data_mover_bram_v2: RTL and testbench
=====================================

DATA_MOVER_BRAM_V2 -- requirements
Module: data_mover_bram_v2

Interface
REQ-001 Parameter DWIDTH, default 32: data width of both BRAM ports.
REQ-002 Parameter AWIDTH, default 12: address width of both BRAM ports.
REQ-003 Parameter CNT_BIT, default 13: transfer-count width.
REQ-004 Parameter CORE_DELAY, default 5, legal range 2..16: core pipeline depth in cycles.
REQ-005 Ports, clock and reset first:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_run  in  1  start pulse.
- i_num_cnt  in  CNT_BIT  words to move.
- i_src_base  in  AWIDTH  first read address in bram0.
- i_dst_base  in  AWIDTH  first write address in bram1.
- i_add  in  DWIDTH  constant added to each word by the core.
- o_idle, o_read, o_write, o_done  out  1  status.
- addr_b0 (out AWIDTH), ce_b0, we_b0 (out 1), q_b0 (in DWIDTH), d_b0 (out DWIDTH): bram0, read side.
- addr_b1 (out AWIDTH), ce_b1, we_b1 (out 1), q_b1 (in DWIDTH, unused), d_b1 (out DWIDTH): bram1, write side.

Function
REQ-006 Single FSM with states S_IDLE, S_RUN, S_DRAIN, S_DONE; the block SHALL capture i_num_cnt, i_src_base, i_dst_base and i_add on i_run in S_IDLE.
REQ-007 S_IDLE -> S_RUN on i_run with i_num_cnt != 0; S_IDLE -> S_DONE on i_run with i_num_cnt == 0, with no memory access.
REQ-008 S_RUN SHALL issue one read per cycle (ce_b0=1, addr_b0 = src_base + read index, modulo 2^AWIDTH) and move to S_DRAIN after read num_cnt-1.
REQ-009 S_DRAIN -> S_DONE in the cycle the final write (write index num_cnt-1) is issued; S_DONE -> S_IDLE unconditionally after 1 cycle.
REQ-010 i_run outside S_IDLE SHALL be ignored, and captured values SHALL be unchanged.
REQ-011 Read data is valid 1 cycle after ce_b0; the core SHALL output q_b0 + i_add (truncated to DWIDTH) CORE_DELAY cycles later.
REQ-012 Write timing: ce_b1 = we_b1 = 1 exactly CORE_DELAY+1 cycles after the matching read, with addr_b1 = dst_base + write index (modulo 2^AWIDTH) and d_b1 = the core result.
REQ-013 The write index SHALL advance only on we_b1, and both indices SHALL clear to 0 on entry to S_DONE.
REQ-014 Status outputs: o_idle = (S_IDLE); o_read = ce_b0; o_write = (S_RUN or S_DRAIN); o_done = (S_DONE), a 1-cycle pulse.
REQ-015 Constant outputs: we_b0 = 0 and d_b0 = 0 at all times.
REQ-016 Pipeline valid bits SHALL be cleared in S_IDLE so that no stale write can occur on a following run; pipeline data need not be cleared.
REQ-017 Address overlap between the src and dst ranges is undefined behaviour; the block SHALL NOT check for it.

Reset
REQ-018 While reset_n=0: FSM = S_IDLE; all counters, captured registers, pipeline valids and data = 0; o_idle=1; all other outputs = 0.
REQ-019 Reset asserted mid-transfer SHALL abort at once with no further BRAM write; after release the block SHALL be idle.

Configuration
REQ-020 With macro DM_SUM_EN defined: output o_sum (DWIDTH+CNT_BIT bits) SHALL accumulate every d_b1 written, clear on accepted i_run, and hold its value after o_done until the next run.
REQ-021 Without DM_SUM_EN: the o_sum port and its logic SHALL be absent.

Structure
REQ-022 The FSM state encodings and the CORE_DELAY legal-range constants SHALL live in package dm_pkg.
REQ-023 The valid/data delay line plus adder SHALL be sub-module dm_core_pipe (parameters DWIDTH, CORE_DELAY).

Verification
REQ-024 Basic copy: num_cnt=8, src=0, dst=0x100, add=0, bram0[i]=i -> bram1[0x100..0x107]=0..7; first we_b1 6 cycles after first ce_b0; o_done 1 cycle after last write.
REQ-025 Wrap with add: src=0xFFE, dst=0xFFF, num_cnt=4, add=5 -> reads 0xFFE,0xFFF,0x000,0x001; writes 0xFFF,0x000,0x001,0x002 with data+5.
REQ-026 Zero count: num_cnt=0 -> o_done 1 cycle after i_run; ce_b0 and ce_b1 never asserted.
REQ-027 Ignored restart: i_run re-pulsed mid-transfer with num_cnt=3 -> original 8-word run completes unchanged, then two back-to-back runs leave no stale writes.
REQ-028 Reset mid-run: reset_n low at word 4 of 8 -> no we_b1 after assertion, o_idle=1; with DM_SUM_EN, o_sum equals the sum of the 8 written words after a clean run.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state encoding and legal core-delay range for the data mover.
package dm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } dm_state_t;

  localparam int CORE_DELAY_MIN = 2;
  localparam int CORE_DELAY_MAX = 16;

endpackage

// File: rtl/dm_core_pipe.sv
// dm_core_pipe: adds a constant to each read word and delays data and valid
// by CORE_DELAY cycles. Valids can be flushed with clr; data is left alone.
module dm_core_pipe
  import dm_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int CORE_DELAY = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [DWIDTH-1:0] add,
  output logic              out_vld,
  output logic [DWIDTH-1:0] out_data
);

  if (CORE_DELAY < CORE_DELAY_MIN || CORE_DELAY > CORE_DELAY_MAX) begin : g_bad_delay
    $error("dm_core_pipe: CORE_DELAY out of range");
  end

  // Modular add: the carry out of the top bit is dropped.
  function automatic logic [DWIDTH-1:0] add_wrap(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
    return a + b;
  endfunction

  logic [CORE_DELAY-1:0] vld_p;
  logic [DWIDTH-1:0]     data_p [CORE_DELAY];

  // Valid shift register; flushed whenever the mover is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[CORE_DELAY-2:0], in_vld};
    end
  end

  // Data shift register; stage 0 holds the sum, later stages just delay it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CORE_DELAY; i++) data_p[i] <= '0;
    end else begin
      data_p[0] <= add_wrap(in_data, add);
      for (int i = 1; i < CORE_DELAY; i++) data_p[i] <= data_p[i-1];
    end
  end

  assign out_vld  = vld_p[CORE_DELAY-1];
  assign out_data = data_p[CORE_DELAY-1];

endmodule

// File: rtl/data_mover_bram_v2.sv
// data_mover_bram_v2: streams i_num_cnt words from bram0 to bram1, adding i_add
// to each. Optional feature macro DM_SUM_EN adds o_sum, the running total of
// every word written during the current/last run.
module data_mover_bram_v2
  import dm_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 12,
  parameter int CNT_BIT    = 13,
  parameter int CORE_DELAY = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic [AWIDTH-1:0]  i_src_base,
  input  logic [AWIDTH-1:0]  i_dst_base,
  input  logic [DWIDTH-1:0]  i_add,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_write,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr_b0,
  output logic               ce_b0,
  output logic               we_b0,
  input  logic [DWIDTH-1:0]  q_b0,
  output logic [DWIDTH-1:0]  d_b0,
  output logic [AWIDTH-1:0]  addr_b1,
  output logic               ce_b1,
  output logic               we_b1,
  input  logic [DWIDTH-1:0]  q_b1,
  output logic [DWIDTH-1:0]  d_b1
`ifdef DM_SUM_EN
  ,
  output logic [DWIDTH+CNT_BIT-1:0] o_sum
`endif
);

  dm_state_t          state, state_nxt;
  logic [CNT_BIT-1:0] num_cnt;
  logic [AWIDTH-1:0]  src_base, dst_base;
  logic [DWIDTH-1:0]  add_val;
  logic [CNT_BIT-1:0] rd_idx, wr_idx;
  logic [CNT_BIT-1:0] last_idx;
  logic               run_accept;
  logic               done_entry;
  logic               rd_vld_p0;
  logic               core_vld;
  logic [DWIDTH-1:0]  core_data;
  logic               wr_fire;
  logic               busy;

  // bram1 is write-only from this block.
  logic unused_q_b1;
  assign unused_q_b1 = ^q_b1;

  assign last_idx   = num_cnt - CNT_BIT'(1);
  assign run_accept = (state == S_IDLE) && i_run;
  assign done_entry = (state != S_DONE) && (state_nxt == S_DONE);
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign wr_fire    = core_vld && busy;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and read strobe.
  always_comb begin
    state_nxt = state;
    ce_b0     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_run) state_nxt = (i_num_cnt != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        ce_b0 = 1'b1;
        if (rd_idx == last_idx) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_fire && (wr_idx == last_idx)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Job parameters, latched only when a run is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_cnt  <= '0;
      src_base <= '0;
      dst_base <= '0;
      add_val  <= '0;
    end else if (run_accept) begin
      num_cnt  <= i_num_cnt;
      src_base <= i_src_base;
      dst_base <= i_dst_base;
      add_val  <= i_add;
    end
  end

  // Read/write indices; both return to zero as the job finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
    end else if (done_entry) begin
      rd_idx <= '0;
      wr_idx <= '0;
    end else begin
      if (ce_b0)   rd_idx <= rd_idx + CNT_BIT'(1);
      if (wr_fire) wr_idx <= wr_idx + CNT_BIT'(1);
    end
  end

  // Read-latency stage: marks q_b0 as valid one cycle after ce_b0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld_p0 <= 1'b0;
    else          rd_vld_p0 <= ce_b0;
  end

  dm_core_pipe #(
    .DWIDTH     (DWIDTH),
    .CORE_DELAY (CORE_DELAY)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state == S_IDLE),
    .in_vld   (rd_vld_p0),
    .in_data  (q_b0),
    .add      (add_val),
    .out_vld  (core_vld),
    .out_data (core_data)
  );

  assign addr_b0 = src_base + AWIDTH'(rd_idx);
  assign we_b0   = 1'b0;
  assign d_b0    = '0;

  assign addr_b1 = dst_base + AWIDTH'(wr_idx);
  assign ce_b1   = wr_fire;
  assign we_b1   = wr_fire;
  assign d_b1    = core_data;

  assign o_idle  = (state == S_IDLE);
  assign o_read  = ce_b0;
  assign o_write = busy;
  assign o_done  = (state == S_DONE);

`ifdef DM_SUM_EN
  localparam int SUM_W = DWIDTH + CNT_BIT;

  // Running total of written words; restarts with each accepted run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        o_sum <= '0;
    else if (run_accept) o_sum <= '0;
    else if (wr_fire)    o_sum <= o_sum + SUM_W'(d_b1);
  end
`endif

endmodule

// File: tb/tb_data_mover_bram_v2.sv
// tb_data_mover_bram_v2: randomized bench with BRAM models and a job-level
// reference model (expected address/data streams and latencies per job).
module tb_data_mover_bram_v2;

  localparam int DWIDTH     = 32;
  localparam int AWIDTH     = 12;
  localparam int CNT_BIT    = 13;
  localparam int CORE_DELAY = 5;
  localparam int DEPTH      = 1 << AWIDTH;
  localparam int SUM_W      = DWIDTH + CNT_BIT;

  logic               clk;
  logic               reset_n;
  logic               i_run;
  logic [CNT_BIT-1:0] i_num_cnt;
  logic [AWIDTH-1:0]  i_src_base, i_dst_base;
  logic [DWIDTH-1:0]  i_add;
  logic               o_idle, o_read, o_write, o_done;
  logic [AWIDTH-1:0]  addr_b0, addr_b1;
  logic               ce_b0, we_b0, ce_b1, we_b1;
  logic [DWIDTH-1:0]  q_b0, d_b0, q_b1, d_b1;
`ifdef DM_SUM_EN
  logic [SUM_W-1:0]   o_sum;
`endif

  data_mover_bram_v2 #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .CNT_BIT(CNT_BIT), .CORE_DELAY(CORE_DELAY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base), .i_add(i_add),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .q_b0(q_b0), .d_b0(d_b0),
    .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .q_b1(q_b1), .d_b1(d_b1)
`ifdef DM_SUM_EN
    , .o_sum(o_sum)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit const_bad = 0;

  logic [DWIDTH-1:0] bram0 [DEPTH];
  logic [DWIDTH-1:0] bram1 [DEPTH];

  int                rd_cyc_q [$];
  logic [AWIDTH-1:0] rd_addr_q [$];
  int                wr_cyc_q [$];
  logic [AWIDTH-1:0] wr_addr_q [$];
  logic [DWIDTH-1:0] wr_data_q [$];
  int                done_q [$];

  logic [DWIDTH-1:0] pend_d;
  bit                pend_v;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // BRAM models and event logger, all sampled on the falling edge.
  initial begin
    q_b0   = '0;
    q_b1   = '0;
    pend_v = 0;
    pend_d = '0;
    forever begin
      @(negedge clk);
      if (pend_v) q_b0 = pend_d;
      pend_v = ce_b0;
      pend_d = bram0[addr_b0];
      if (ce_b0) begin
        rd_cyc_q.push_back(cyc);
        rd_addr_q.push_back(addr_b0);
      end
      if (we_b1) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(addr_b1);
        wr_data_q.push_back(d_b1);
        bram1[addr_b1] = d_b1;
      end
      if (o_done) done_q.push_back(cyc);
      if (we_b0 !== 1'b0 || d_b0 !== '0 || o_read !== ce_b0 || ce_b1 !== we_b1 ||
          (we_b1 && !o_write))
        const_bad = 1;
    end
  end

  task automatic clear_log();
    rd_cyc_q.delete(); rd_addr_q.delete();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_q.delete();
  endtask

  // Runs one job and checks it against the expected streams. Called and
  // returns 1 time unit after a rising edge, so jobs can run back to back.
  task automatic run_job(input int n, input logic [AWIDTH-1:0] src,
                         input logic [AWIDTH-1:0] dst, input logic [DWIDTH-1:0] add,
                         input bit restart);
    int run_cyc;
    int budget;
    int lim;
    logic [AWIDTH-1:0] ra, wa;
    logic [DWIDTH-1:0] exp_d;
    logic [SUM_W-1:0]  exp_sum;
    check_eq("quiet_before_run", 64'(rd_cyc_q.size() + wr_cyc_q.size() + done_q.size()), 64'd0);
    i_run      = 1'b1;
    i_num_cnt  = CNT_BIT'(n);
    i_src_base = src;
    i_dst_base = dst;
    i_add      = add;
    run_cyc    = cyc;
    @(posedge clk); #1;
    i_run      = 1'b0;
    i_num_cnt  = CNT_BIT'($urandom_range(0, 50));
    i_src_base = AWIDTH'($urandom);
    i_dst_base = AWIDTH'($urandom);
    i_add      = $urandom;
    if (restart) begin
      repeat (2) begin @(posedge clk); #1; end
      i_run     = 1'b1;
      i_num_cnt = CNT_BIT'(3);
      @(posedge clk); #1;
      i_run     = 1'b0;
    end
    budget = n + CORE_DELAY + 40;
    while (done_q.size() == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (done_q.size() == 0) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      clear_log();
      return;
    end
    check_eq("n_reads", 64'(rd_cyc_q.size()), 64'(n));
    check_eq("n_writes", 64'(wr_cyc_q.size()), 64'(n));
    check_eq("n_done", 64'(done_q.size()), 64'd1);
    if (n == 0) begin
      check_eq("zero_done_lat", 64'(done_q[0] - run_cyc), 64'd1);
    end else begin
      if (rd_cyc_q.size() > 0)
        check_eq("first_rd_lat", 64'(rd_cyc_q[0] - run_cyc), 64'd1);
      lim = n;
      if (rd_cyc_q.size() < lim) lim = rd_cyc_q.size();
      if (wr_cyc_q.size() < lim) lim = wr_cyc_q.size();
      exp_sum = '0;
      for (int k = 0; k < lim; k++) begin
        ra    = src + AWIDTH'(k);
        wa    = dst + AWIDTH'(k);
        exp_d = bram0[ra] + add;
        exp_sum = exp_sum + SUM_W'(exp_d);
        check_eq($sformatf("rd_addr[%0d]", k), 64'(rd_addr_q[k]), 64'(ra));
        check_eq($sformatf("wr_addr[%0d]", k), 64'(wr_addr_q[k]), 64'(wa));
        check_eq($sformatf("wr_data[%0d]", k), 64'(wr_data_q[k]), 64'(exp_d));
        check_eq($sformatf("wr_lat[%0d]", k), 64'(wr_cyc_q[k] - rd_cyc_q[k]), 64'(CORE_DELAY + 1));
        check_eq($sformatf("bram1[%0d]", k), 64'(bram1[wa]), 64'(exp_d));
      end
      if (wr_cyc_q.size() > 0)
        check_eq("done_after_wr", 64'(done_q[0] - wr_cyc_q[wr_cyc_q.size()-1]), 64'd1);
`ifdef DM_SUM_EN
      check_eq("sum", 64'(o_sum), 64'(exp_sum));
`endif
    end
    clear_log();
  endtask

  initial begin
    int cnt;
    int budget;
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_num_cnt  = '0;
    i_src_base = '0;
    i_dst_base = '0;
    i_add      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bram0[i] = DWIDTH'(i);
      bram1[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_idle", 64'(o_idle), 64'd1);
    check_eq("rst_read", 64'(o_read), 64'd0);
    check_eq("rst_write", 64'(o_write), 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_ce_b0", 64'(ce_b0), 64'd0);
    check_eq("rst_we_b0", 64'(we_b0), 64'd0);
    check_eq("rst_addr_b0", 64'(addr_b0), 64'd0);
    check_eq("rst_d_b0", 64'(d_b0), 64'd0);
    check_eq("rst_ce_b1", 64'(ce_b1), 64'd0);
    check_eq("rst_we_b1", 64'(we_b1), 64'd0);
    check_eq("rst_addr_b1", 64'(addr_b1), 64'd0);
    check_eq("rst_d_b1", 64'(d_b1), 64'd0);
`ifdef DM_SUM_EN
    check_eq("rst_sum", 64'(o_sum), 64'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_log();

    // Basic copy, wrap with add, zero count.
    run_job(8, 12'h000, 12'h100, 32'd0, 0);
    run_job(4, 12'hFFE, 12'hFFF, 32'd5, 0);
    run_job(0, 12'h123, 12'h456, 32'd9, 0);

    // Restart pulse ignored, then two back-to-back runs.
    for (int i = 0; i < DEPTH; i++) bram0[i] = $urandom;
    run_job(8, 12'h040, 12'h200, $urandom, 1);
    run_job(5, AWIDTH'($urandom), AWIDTH'($urandom), $urandom, 0);
    run_job(3, AWIDTH'($urandom), AWIDTH'($urandom), $urandom, 0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      for (int i = 0; i < DEPTH; i++) bram0[i] = $urandom;
      run_job(n, AWIDTH'($urandom), AWIDTH'($urandom), $urandom,
              (n >= 3) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
    end

    // Reset in the middle of an 8-word run.
    i_run      = 1'b1;
    i_num_cnt  = CNT_BIT'(8);
    i_src_base = 12'h010;
    i_dst_base = 12'h300;
    i_add      = 32'd1;
    @(posedge clk); #1;
    i_run  = 1'b0;
    budget = 30;
    while (rd_cyc_q.size() < 4 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check_eq("midrst_reached_word4", 64'(rd_cyc_q.size() >= 4), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_idle", 64'(o_idle), 64'd1);
    check_eq("midrst_we_b1", 64'(we_b1), 64'd0);
    check_eq("midrst_ce_b0", 64'(ce_b0), 64'd0);
    cnt = wr_cyc_q.size();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_no_writes", 64'(wr_cyc_q.size()), 64'(cnt));
    check_eq("midrst_idle_after", 64'(o_idle), 64'd1);
    clear_log();

    // Clean run after the abort; total must hold once done.
    run_job(8, 12'h010, 12'h300, 32'd7, 0);
`ifdef DM_SUM_EN
    begin
      logic [SUM_W-1:0] held;
      held = o_sum;
      repeat (4) begin @(posedge clk); #1; end
      check_eq("sum_hold", 64'(o_sum), 64'(held));
    end
`endif

    check_eq("constant_outputs", 64'(const_bad), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
